rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen, write address, WD) between two writeback requesters: A (ALU writeback) and B (load-unit writeback).
- Each requester has a 2-deep input FIFO. A round-robin arbiter pops one FIFO head per cycle into a registered output stage that drives the register file.
- Publishes a 32-bit busy mask of registers with accepted-but-not-yet-written writes, which decode uses for stall and hazard checks.

Parameters:
- DEPTH, 2, entries per requester FIFO (fixed at 2; the sequence-number width depends on it).
- SEQ_W, 4, width of the arrival sequence tag.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write.
- a_ready  output  1  A FIFO not full.
- a_addr  input  5  A destination register.
- a_data  input  32  A write data.
- b_valid  input  1  requester B has a write.
- b_ready  output  1  B FIFO not full.
- b_addr  input  5  B destination register.
- b_data  input  32  B write data.
- hold  input  1  freeze issue from FIFOs to the output stage.
- rf_wen  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- busy_mask  output  32  bit i set while a write to register i is in flight.

Behaviour:
- Reset:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, busy_mask=0.
  - Both FIFOs empty, so a_ready=b_ready=1.
  - Round-robin pointer = A. Sequence counter = 0.
- Accept:
  - An entry is pushed when valid && ready, regardless of hold.
  - ready depends only on FIFO occupancy (combinational from registered count). It is never a function of valid.
- Tagging:
  - Each accepted entry gets a SEQ_W-bit tag from a global counter.
  - If A and B are accepted in the same cycle, A gets n and B gets n+1; the counter then advances by 2. Otherwise it advances by the number accepted.
  - The counter wraps modulo 16.
- Issue (per cycle, when hold=0):
  - If exactly one FIFO is non-empty, pop its head.
  - If both are non-empty and the head addresses differ, pop the requester selected by the round-robin pointer. The pointer then moves to the other requester.
  - If both are non-empty and the head addresses are equal and nonzero, pop the older head. Older means (tagB - tagA) mod 16 in 1..7, which selects A; otherwise B. The pointer is unchanged.
  - The popped entry is loaded into the output stage.
- Output stage and latency:
  - rf_wen=1 for exactly one cycle, in the cycle after the pop, with the popped waddr/wdata.
  - Otherwise rf_wen=0; waddr/wdata hold their last values.
  - Minimum latency from accept to rf_wen is 2 cycles: push at edge k, pop at edge k+1, rf_wen high after edge k+1.
- hold=1:
  - No pop.
  - The output stage still retires the current entry: rf_wen drops after one cycle.
  - The FIFOs keep accepting until full.
- Register $0:
  - Writes to address 0 are accepted, tagged and issued normally, but rf_wen is forced to 0 for them.
  - Address 0 never sets a busy_mask bit.
- busy_mask: OR of one-hot(addr) over all valid FIFO entries plus the output stage while rf_wen=1; bit 0 is masked.
- Same-cycle push and pop on a full FIFO: not allowed. ready=0 when the count is 2, even if a pop is occurring that cycle.
- Reset asserted mid-operation: all FIFO entries and the output stage are discarded. rf_wen=0 in the cycle after rst is sampled. No partial write is issued.

Test Plan:
- Single write: A pushes addr 5, data 0x1234 at cycle 0 -> rf_wen=1, rf_waddr=5, rf_wdata=0x1234 at cycle 2. busy_mask[5]=1 during cycles 1-2, then 0.
- Contention: A and B both push every cycle with different addresses -> issued sequence alternates A,B,A,B. a_ready/b_ready drop when the respective FIFO holds 2 entries.
- Ordering: B pushes r7=0xB at cycle 0; A pushes r7=0xA at cycle 1 while the pointer is at A -> the r7 write of 0xB issues before 0xA, and the final register value is 0xA.
- Register zero: A pushes addr 0, data 0xFFFF -> rf_wen stays 0 and busy_mask stays 0. The pointer and the next write are unaffected.
- Hold: fill both FIFOs (4 entries) with hold=1 -> no rf_wen, both ready=0, busy_mask shows 4 bits. Release hold -> 4 writes on consecutive cycles, then busy_mask=0.
- Reset mid-flight: rst=1 for one cycle with 3 entries queued -> rf_wen=0 the next cycle, busy_mask=0, both ready=1, and the sequence counter restarts at 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the two writeback request channels, issue hold, and the
// register-file write port plus busy mask published to decode.
interface rf_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
    input  a_ready, b_ready, rf_wen, rf_waddr, rf_wdata, busy_mask
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
    output a_ready, b_ready, rf_wen, rf_waddr, rf_wdata, busy_mask
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter: 2-deep tagged FIFOs per
// requester, round-robin issue with oldest-first ordering on same-register heads.
module rf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  typedef struct packed {
    logic [4:0]       addr;
    logic [31:0]      data;
    logic [SEQ_W-1:0] tag;
  } entry_t;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  entry_t           a_mem_q [DEPTH];
  entry_t           a_mem_d [DEPTH];
  entry_t           b_mem_q [DEPTH];
  entry_t           b_mem_d [DEPTH];
  logic [1:0]       a_cnt_q, a_cnt_d;
  logic [1:0]       b_cnt_q, b_cnt_d;
  logic             rr_q, rr_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      busy_q, busy_d;

  logic             a_ready_s, b_ready_s;
  logic             push_a_s, push_b_s;
  logic             pop_a_s, pop_b_s;
  logic [SEQ_W-1:0] tag_a_s, tag_b_s;
  logic [SEQ_W-1:0] age_s;
  entry_t           issue_s;

  // Ready is a pure function of registered occupancy, never of valid.
  assign a_ready_s = (a_cnt_q != FULL_CNT);
  assign b_ready_s = (b_cnt_q != FULL_CNT);
  assign push_a_s  = bus.a_valid & a_ready_s;
  assign push_b_s  = bus.b_valid & b_ready_s;
  assign age_s     = b_mem_q[0].tag - a_mem_q[0].tag;
  assign issue_s   = pop_a_s ? a_mem_q[0] : b_mem_q[0];

  // Arrival tagging: A takes the lower tag when both arrive together.
  always_comb begin
    tag_a_s = seq_q;
    tag_b_s = seq_q + {{(SEQ_W-1){1'b0}}, push_a_s};
    seq_d   = seq_q + {{(SEQ_W-1){1'b0}}, push_a_s} + {{(SEQ_W-1){1'b0}}, push_b_s};
  end

  // Issue selection; same-register heads drain oldest first without moving the pointer.
  always_comb begin
    pop_a_s = 1'b0;
    pop_b_s = 1'b0;
    rr_d    = rr_q;
    if (!bus.hold) begin
      if ((a_cnt_q != 2'd0) && (b_cnt_q == 2'd0)) begin
        pop_a_s = 1'b1;
      end else if ((a_cnt_q == 2'd0) && (b_cnt_q != 2'd0)) begin
        pop_b_s = 1'b1;
      end else if ((a_cnt_q != 2'd0) && (b_cnt_q != 2'd0)) begin
        if ((a_mem_q[0].addr == b_mem_q[0].addr) && (a_mem_q[0].addr != 5'd0)) begin
          // age in 1..half-range means B arrived after A
          if ((age_s != {SEQ_W{1'b0}}) && !age_s[SEQ_W-1]) begin
            pop_a_s = 1'b1;
          end else begin
            pop_b_s = 1'b1;
          end
        end else begin
          pop_a_s = ~rr_q;
          pop_b_s = rr_q;
          rr_d    = ~rr_q;
        end
      end else begin
        rr_d = rr_q;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Shift-style FIFOs: slot 0 is always the head.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (pop_a_s) begin
      a_mem_d[0] = a_mem_q[1];
      a_cnt_d    = a_cnt_q - 2'd1;
    end else begin
      a_cnt_d = a_cnt_q;
    end
    if (pop_b_s) begin
      b_mem_d[0] = b_mem_q[1];
      b_cnt_d    = b_cnt_q - 2'd1;
    end else begin
      b_cnt_d = b_cnt_q;
    end
    if (push_a_s) begin
      a_mem_d[a_cnt_d[0]] = {bus.a_addr, bus.a_data, tag_a_s};
      a_cnt_d             = a_cnt_d + 2'd1;
    end else begin
      a_cnt_d = a_cnt_d;
    end
    if (push_b_s) begin
      b_mem_d[b_cnt_d[0]] = {bus.b_addr, bus.b_data, tag_b_s};
      b_cnt_d             = b_cnt_d + 2'd1;
    end else begin
      b_cnt_d = b_cnt_d;
    end
  end

  // Output stage: one-cycle write strobe, suppressed for register zero.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pop_a_s || pop_b_s) begin
      wen_d   = (issue_s.addr != 5'd0);
      waddr_d = issue_s.addr;
      wdata_d = issue_s.data;
    end else begin
      wen_d = 1'b0;
    end
  end

  // Busy mask built from next-state contents so it can be registered.
  always_comb begin
    busy_d = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[a_mem_d[i].addr] = busy_d[a_mem_d[i].addr] | (i < int'(a_cnt_d));
      busy_d[b_mem_d[i].addr] = busy_d[b_mem_d[i].addr] | (i < int'(b_cnt_d));
    end
    busy_d[waddr_d] = busy_d[waddr_d] | wen_d;
    busy_d[0]       = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
      a_cnt_q <= 2'd0;
      b_cnt_q <= 2'd0;
      rr_q    <= 1'b0;
      seq_q   <= {SEQ_W{1'b0}};
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'h0000_0000;
      busy_q  <= 32'h0000_0000;
    end else begin
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      rr_q    <= rr_d;
      seq_q   <= seq_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.a_ready   = a_ready_s;
  assign bus.b_ready   = b_ready_s;
  assign bus.rf_wen    = wen_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.busy_mask = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus a randomized run scored
// against a queue-based reference model of the writeback arbiter.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.DEPTH(2), .SEQ_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          tag;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  int          m_seq;
  bit          m_rr_b;
  logic        exp_wen;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] mdl_rf [32];
  logic [31:0] dut_rf [32];

  // Reference model: queues per requester, evaluated on each rising edge.
  always @(posedge clk) begin : model
    bit   acc_a, acc_b, take_a, take_b;
    int   age;
    ent_t e;
    if (rst) begin
      qa.delete(); qb.delete();
      m_seq = 0; m_rr_b = 1'b0;
      exp_wen = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'h0;
    end else begin
      acc_a  = bus.a_valid && (qa.size() < 2);
      acc_b  = bus.b_valid && (qb.size() < 2);
      take_a = 1'b0;
      take_b = 1'b0;
      if (!bus.hold) begin
        if (qa.size() > 0 && qb.size() > 0) begin
          if (qa[0].addr == qb[0].addr && qa[0].addr != 5'd0) begin
            age    = (qb[0].tag - qa[0].tag + 16) % 16;
            take_a = (age >= 1 && age <= 7);
            take_b = !take_a;
          end else begin
            take_a = !m_rr_b;
            take_b = m_rr_b;
            m_rr_b = !m_rr_b;
          end
        end else begin
          take_a = (qa.size() > 0);
          take_b = (qb.size() > 0);
        end
      end
      exp_wen = 1'b0;
      if (take_a) e = qa.pop_front();
      else if (take_b) e = qb.pop_front();
      if (take_a || take_b) begin
        exp_waddr = e.addr;
        exp_wdata = e.data;
        exp_wen   = (e.addr != 5'd0);
        if (exp_wen) mdl_rf[e.addr] = e.data;
      end
      if (acc_a) qa.push_back('{bus.a_addr, bus.a_data, m_seq});
      if (acc_b) qb.push_back('{bus.b_addr, bus.b_data, (m_seq + int'(acc_a)) % 16});
      m_seq = (m_seq + int'(acc_a) + int'(acc_b)) % 16;
    end
  end

  // Shadow register file reconstructed from observed DUT writes.
  always @(negedge clk) begin
    if (bus.rf_wen === 1'b1) dut_rf[bus.rf_waddr] = bus.rf_wdata;
  end

  function automatic logic [31:0] mdl_busy();
    logic [31:0] m;
    m = 32'h0;
    foreach (qa[i]) m[qa[i].addr] = 1'b1;
    foreach (qb[i]) m[qb[i].addr] = 1'b1;
    if (exp_wen) m[exp_waddr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic clear_inputs();
    bus.a_valid = 1'b0; bus.a_addr = 5'd0; bus.a_data = 32'h0;
    bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'h0;
    bus.hold    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (bus.rf_wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", bus.rf_wen); else n_pass++;
    if (bus.rf_waddr !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); else n_pass++;
    if (bus.rf_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.rf_wdata); else n_pass++;
    if (bus.busy_mask !== 32'h0) $display("FAIL reset_busy: got %h want 0", bus.busy_mask); else n_pass++;
    if (bus.a_ready !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", bus.a_ready); else n_pass++;
    if (bus.b_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", bus.b_ready); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    @(negedge clk);
    bus.a_valid = 1'b0;
    n_checks += 2;
    if (bus.busy_mask !== 32'h20) $display("FAIL single_busy_c1: got %h want 00000020", bus.busy_mask); else n_pass++;
    if (bus.rf_wen !== 1'b0) $display("FAIL single_wen_c1: got %b want 0", bus.rf_wen); else n_pass++;
    @(negedge clk);
    n_checks += 4;
    if (bus.rf_wen !== 1'b1) $display("FAIL single_wen_c2: got %b want 1", bus.rf_wen); else n_pass++;
    if (bus.rf_waddr !== 5'd5) $display("FAIL single_waddr: got %0d want 5", bus.rf_waddr); else n_pass++;
    if (bus.rf_wdata !== 32'h1234) $display("FAIL single_wdata: got %h want 1234", bus.rf_wdata); else n_pass++;
    if (bus.busy_mask !== 32'h20) $display("FAIL single_busy_c2: got %h want 00000020", bus.busy_mask); else n_pass++;
    @(negedge clk);
    n_checks += 2;
    if (bus.rf_wen !== 1'b0) $display("FAIL single_wen_c3: got %b want 0", bus.rf_wen); else n_pass++;
    if (bus.busy_mask !== 32'h0) $display("FAIL single_busy_c3: got %h want 0", bus.busy_mask); else n_pass++;
  endtask

  task automatic test_contention();
    int nw;
    bit acc_a, acc_b, saw_a_full, saw_b_full;
    do_reset();
    nw = 0; saw_a_full = 1'b0; saw_b_full = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h100;
    for (int c = 0; c < 12; c++) begin
      acc_a = bus.a_ready;
      acc_b = bus.b_ready;
      @(negedge clk);
      if (acc_a) bus.a_data = bus.a_data + 32'h1;
      if (acc_b) bus.b_data = bus.b_data + 32'h1;
      if (!bus.a_ready) saw_a_full = 1'b1;
      if (!bus.b_ready) saw_b_full = 1'b1;
      if (bus.rf_wen === 1'b1) begin
        n_checks += 2;
        if (bus.rf_waddr !== ((nw % 2 == 0) ? 5'd3 : 5'd9))
          $display("FAIL contention_order w%0d: got addr %0d want %0d", nw, bus.rf_waddr, (nw % 2 == 0) ? 3 : 9);
        else n_pass++;
        if (bus.rf_wdata !== ((nw % 2 == 0) ? 32'(nw / 2) : 32'h100 + 32'(nw / 2)))
          $display("FAIL contention_data w%0d: got %h", nw, bus.rf_wdata);
        else n_pass++;
        nw++;
      end
    end
    clear_inputs();
    n_checks += 3;
    if (nw !== 11) $display("FAIL contention_count: got %0d writes want 11", nw); else n_pass++;
    if (!saw_a_full) $display("FAIL contention_a_full: got ready always 1 want a 0"); else n_pass++;
    if (!saw_b_full) $display("FAIL contention_b_full: got ready always 1 want a 0"); else n_pass++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_ordering(input bit hold_mode);
    logic [31:0] got[$];
    do_reset();
    bus.hold = hold_mode;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'hB; end
        1: begin bus.b_valid = 1'b0; bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hA; end
        2: bus.a_valid = 1'b0;
        3: bus.hold = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (bus.rf_wen === 1'b1 && bus.rf_waddr === 5'd7) got.push_back(bus.rf_wdata);
    end
    n_checks += 3;
    if (got.size() != 2) $display("FAIL ordering_count h%0d: got %0d want 2", hold_mode, got.size());
    else n_pass++;
    if (got.size() < 2 || got[0] !== 32'hB || got[1] !== 32'hA)
      $display("FAIL ordering_seq h%0d: got first %h want B then A", hold_mode, (got.size() > 0) ? got[0] : 32'hx);
    else n_pass++;
    if (dut_rf[7] !== 32'hA) $display("FAIL ordering_final h%0d: got %h want a", hold_mode, dut_rf[7]);
    else n_pass++;
  endtask

  task automatic test_reg_zero();
    logic [36:0] wr[$];
    bit zero_wen;
    do_reset();
    zero_wen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF; end
        1: bus.a_valid = 1'b0;
        2: begin
          bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h44;
          bus.b_valid = 1'b1; bus.b_addr = 5'd6; bus.b_data = 32'h66;
        end
        3: begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
      if (bus.rf_wen === 1'b1) begin
        wr.push_back({bus.rf_waddr, bus.rf_wdata});
        if (bus.rf_waddr === 5'd0) zero_wen = 1'b1;
      end
      if (c < 2) begin
        n_checks++;
        if (bus.busy_mask !== 32'h0) $display("FAIL zero_busy c%0d: got %h want 0", c, bus.busy_mask); else n_pass++;
      end
      if (c == 2) begin
        n_checks++;
        if (bus.busy_mask !== 32'h50) $display("FAIL zero_busy_next: got %h want 00000050", bus.busy_mask); else n_pass++;
      end
    end
    n_checks += 3;
    if (zero_wen) $display("FAIL zero_wen: got wen for r0 want none"); else n_pass++;
    if (wr.size() != 2) $display("FAIL zero_next_count: got %0d want 2", wr.size()); else n_pass++;
    if (wr.size() < 2 || wr[0] !== {5'd4, 32'h44} || wr[1] !== {5'd6, 32'h66})
      $display("FAIL zero_next_order: got %h want r4=44 then r6=66", (wr.size() > 0) ? wr[0] : 37'hx);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [4:0] exp_addr [4];
    exp_addr = '{5'd1, 5'd10, 5'd2, 5'd11};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: begin
          bus.hold = 1'b1;
          bus.a_valid = 1'b1; bus.a_addr = 5'd1;  bus.a_data = 32'hA1;
          bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'hB10;
        end
        1: begin bus.a_addr = 5'd2; bus.a_data = 32'hA2; bus.b_addr = 5'd11; bus.b_data = 32'hB11; end
        2: begin bus.a_addr = 5'd20; bus.b_addr = 5'd21; end
        4: begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.hold = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        n_checks += 3;
        if (bus.a_ready !== 1'b0) $display("FAIL hold_a_ready c%0d: got %b want 0", c, bus.a_ready); else n_pass++;
        if (bus.b_ready !== 1'b0) $display("FAIL hold_b_ready c%0d: got %b want 0", c, bus.b_ready); else n_pass++;
        if (bus.busy_mask !== 32'hC06) $display("FAIL hold_busy c%0d: got %h want 00000c06", c, bus.busy_mask); else n_pass++;
      end
      if (c <= 3) begin
        n_checks++;
        if (bus.rf_wen !== 1'b0) $display("FAIL hold_wen c%0d: got %b want 0", c, bus.rf_wen); else n_pass++;
      end else if (c <= 7) begin
        n_checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== exp_addr[c-4])
          $display("FAIL hold_drain c%0d: got wen %b addr %0d want 1 addr %0d", c, bus.rf_wen, bus.rf_waddr, exp_addr[c-4]);
        else n_pass++;
      end else begin
        n_checks += 2;
        if (bus.rf_wen !== 1'b0) $display("FAIL hold_end_wen: got %b want 0", bus.rf_wen); else n_pass++;
        if (bus.busy_mask !== 32'h0) $display("FAIL hold_end_busy: got %h want 0", bus.busy_mask); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin
          bus.hold = 1'b1;
          bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h33;
          bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h44;
        end
        1: begin bus.a_addr = 5'd5; bus.a_data = 32'h55; bus.b_valid = 1'b0; end
        2: begin bus.a_valid = 1'b0; bus.hold = 1'b0; rst = 1'b1; end
        3: rst = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (bus.busy_mask !== 32'h38) $display("FAIL midrst_pre_busy: got %h want 00000038", bus.busy_mask); else n_pass++;
      end
      if (c == 2) begin
        n_checks += 3;
        if (bus.busy_mask !== 32'h0) $display("FAIL midrst_busy: got %h want 0", bus.busy_mask); else n_pass++;
        if (bus.a_ready !== 1'b1) $display("FAIL midrst_a_ready: got %b want 1", bus.a_ready); else n_pass++;
        if (bus.b_ready !== 1'b1) $display("FAIL midrst_b_ready: got %b want 1", bus.b_ready); else n_pass++;
      end
      if (c >= 2) begin
        n_checks++;
        if (bus.rf_wen !== 1'b0) $display("FAIL midrst_wen c%0d: got %b want 0", c, bus.rf_wen); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.a_valid = ($urandom_range(0, 99) < 60);
      bus.a_addr  = 5'($urandom_range(0, 7));
      bus.a_data  = $urandom;
      bus.b_valid = ($urandom_range(0, 99) < 60);
      bus.b_addr  = 5'($urandom_range(0, 7));
      bus.b_data  = $urandom;
      bus.hold    = ($urandom_range(0, 99) < 25);
      rst         = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      n_checks += 4;
      if (bus.a_ready !== (qa.size() < 2)) $display("FAIL rand_a_ready c%0d: got %b want %b", c, bus.a_ready, qa.size() < 2); else n_pass++;
      if (bus.b_ready !== (qb.size() < 2)) $display("FAIL rand_b_ready c%0d: got %b want %b", c, bus.b_ready, qb.size() < 2); else n_pass++;
      if (bus.rf_wen !== exp_wen) $display("FAIL rand_wen c%0d: got %b want %b", c, bus.rf_wen, exp_wen); else n_pass++;
      if (bus.busy_mask !== mdl_busy()) $display("FAIL rand_busy c%0d: got %h want %h", c, bus.busy_mask, mdl_busy()); else n_pass++;
      if (exp_wen) begin
        n_checks++;
        if (bus.rf_waddr !== exp_waddr || bus.rf_wdata !== exp_wdata)
          $display("FAIL rand_write c%0d: got r%0d=%h want r%0d=%h", c, bus.rf_waddr, bus.rf_wdata, exp_waddr, exp_wdata);
        else n_pass++;
      end
    end
    rst = 1'b0;
    clear_inputs();
    repeat (6) @(negedge clk);
    bad = 0;
    for (int r = 0; r < 32; r++) if (dut_rf[r] !== mdl_rf[r]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL rand_regfile: got %0d differing registers want 0", bad); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int r = 0; r < 32; r++) begin
      mdl_rf[r] = 32'h0;
      dut_rf[r] = 32'h0;
    end
    test_reset();
    test_single();
    test_contention();
    test_ordering(1'b0);
    test_ordering(1'b1);
    test_reg_zero();
    test_hold();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
